// File: rtl/saph_fpu_issue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : saph_fpu_issue_if
// Purpose  : Bundles the shader-core request channel, the FPU d_*/q_* side and
//            the response channel of the FPU issue stage into one interface.
// Modports : master - environment (shader core + FPU + response consumer)
//            slave  - the issue stage (saph_fpu_issue)
// Signals  : req_*  op request (valid/ready, mode, operands, tag)
//            fpu_*  FPU capability, issue side (d_*), result side (q_*)
//            rsp_*  in-order responses; proto_err sticky protocol flag
// Revision : 1.0 - initial release
// ============================================================================
interface saph_fpu_issue_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic [31:0]      req_lhs;
  logic [31:0]      req_rhs;
  logic [TAG_W-1:0] req_tag;

  logic [3:0]       fpu_has_modes;
  logic             fpu_d_ready;
  logic             fpu_d_trig;
  logic [1:0]       fpu_d_mode;
  logic [31:0]      fpu_d_lhs;
  logic [31:0]      fpu_d_rhs;
  logic             fpu_q_trig;
  logic [31:0]      fpu_q_res;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_res;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             proto_err;

  modport master (
    output req_valid, req_mode, req_lhs, req_rhs, req_tag,
    output fpu_has_modes, fpu_d_ready, fpu_q_trig, fpu_q_res,
    output rsp_ready,
    input  req_ready, fpu_d_trig, fpu_d_mode, fpu_d_lhs, fpu_d_rhs,
    input  rsp_valid, rsp_res, rsp_tag, rsp_err, proto_err
  );

  modport slave (
    input  req_valid, req_mode, req_lhs, req_rhs, req_tag,
    input  fpu_has_modes, fpu_d_ready, fpu_q_trig, fpu_q_res,
    input  rsp_ready,
    output req_ready, fpu_d_trig, fpu_d_mode, fpu_d_lhs, fpu_d_rhs,
    output rsp_valid, rsp_res, rsp_tag, rsp_err, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/saph_fpu_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : saph_fpu_issue
// Purpose  : Issue/retire stage around a single fixed-latency FPU. Accepts
//            tagged float ops, issues supported ones to the FPU, tracks every
//            accepted op in a tag shadow pipeline of LATENCY stages and pushes
//            results (or a quiet-NaN error response) into an in-order FIFO.
//            Issue is credit based: an op is only accepted when the FIFO has
//            room for every op already in flight, so FPU results are never
//            dropped even though the FPU cannot be stalled.
// Ports    : clk, rst (synchronous, active-low)
//            io     - saph_fpu_issue_if.slave (request, FPU and response side)
// Revision : 1.0 - initial release
// ============================================================================
module saph_fpu_issue #(
  parameter int LATENCY    = 2,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  saph_fpu_issue_if.slave io
);

  localparam int          PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int          OCC_W  = CNT_W + 1;  // FIFO count plus up to 4 in flight
  localparam int          DRN_W  = 3;
  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

  logic             w_ready;
  logic             w_accept;
  logic             w_unsup;
  logic             w_tail_valid;
  logic             w_tail_err;
  logic [TAG_W-1:0] w_tail_tag;
  logic [OCC_W-1:0] w_shadow_cnt;
  logic [OCC_W-1:0] w_occ;
  logic             w_drain_mask;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_push_res;
  logic             w_push_err;
  logic             w_proto_set;
  logic             w_rsp_valid;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             proto_q;
  logic [DRN_W-1:0] drain_q;
  logic [31:0]      mem_res_q [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag_q [FIFO_DEPTH];
  logic             mem_err_q [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  // Credits: every op in the shadow will push exactly once, so counting it now
  // guarantees the FIFO slot exists when its result shows up.
  assign w_occ    = OCC_W'(count_q) + w_shadow_cnt;
  assign w_ready  = rst & io.fpu_d_ready & (w_occ < OCC_W'(FIFO_DEPTH));
  assign w_accept = io.req_valid & w_ready;
  assign w_unsup  = ~io.fpu_has_modes[io.req_mode];

  assign io.req_ready  = w_ready;
  assign io.fpu_d_trig = w_accept & ~w_unsup;
  assign io.fpu_d_mode = io.req_mode;
  assign io.fpu_d_lhs  = io.req_lhs;
  assign io.fpu_d_rhs  = io.req_rhs;

  // --------------------------------------------------------------------------
  // Tag shadow pipeline, aligned with the FPU result strobe
  // --------------------------------------------------------------------------
  if (LATENCY == 0) begin : g_no_shadow
    assign w_tail_valid = w_accept;
    assign w_tail_err   = w_unsup;
    assign w_tail_tag   = io.req_tag;
    assign w_shadow_cnt = '0;
  end else begin : g_shadow
    logic [LATENCY-1:0] sh_valid_q;
    logic [LATENCY-1:0] sh_err_q;
    logic [TAG_W-1:0]   sh_tag_q [LATENCY];

    always_ff @(posedge clk) begin
      if (!rst) begin
        sh_valid_q <= '0;
        sh_err_q   <= '0;
      end else begin
        sh_valid_q[0] <= w_accept;
        sh_err_q[0]   <= w_accept & w_unsup;
        for (int i = 1; i < LATENCY; i++) begin
          sh_valid_q[i] <= sh_valid_q[i-1];
          sh_err_q[i]   <= sh_err_q[i-1];
        end
      end
    end

    // Tags are qualified by sh_valid_q and need no reset.
    always_ff @(posedge clk) begin
      sh_tag_q[0] <= io.req_tag;
      for (int i = 1; i < LATENCY; i++) begin
        sh_tag_q[i] <= sh_tag_q[i-1];
      end
    end

    always_comb begin
      w_shadow_cnt = '0;
      for (int i = 0; i < LATENCY; i++) begin
        w_shadow_cnt = w_shadow_cnt + OCC_W'(sh_valid_q[i]);
      end
    end

    assign w_tail_valid = sh_valid_q[LATENCY-1];
    assign w_tail_err   = sh_err_q[LATENCY-1];
    assign w_tail_tag   = sh_tag_q[LATENCY-1];
  end

  // --------------------------------------------------------------------------
  // Retire: match the FPU strobe against the shadow tail
  // --------------------------------------------------------------------------
  // Right after reset, strobes from ops issued before reset may still emerge;
  // they are ignored until LATENCY cycles have elapsed.
  assign w_drain_mask = (drain_q < DRN_W'(LATENCY));

  always_comb begin
    w_push      = 1'b0;
    w_push_res  = io.fpu_q_res;
    w_push_err  = 1'b0;
    w_proto_set = 1'b0;
    if (w_tail_valid) begin
      w_push = 1'b1;
      if (w_tail_err) begin
        w_push_res  = C_QNAN;
        w_push_err  = 1'b1;
        w_proto_set = io.fpu_q_trig;
      end else begin
        w_proto_set = ~io.fpu_q_trig;
      end
    end else begin
      w_proto_set = io.fpu_q_trig & ~w_drain_mask;
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  assign w_rsp_valid = rst & (count_q != '0);
  assign w_pop       = w_rsp_valid & io.rsp_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      proto_q  <= 1'b0;
      drain_q  <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      proto_q  <= proto_q | w_proto_set;
      if (w_drain_mask) begin
        drain_q <= drain_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      mem_res_q[wr_ptr_q] <= w_push_res;
      mem_tag_q[wr_ptr_q] <= w_tail_tag;
      mem_err_q[wr_ptr_q] <= w_push_err;
    end
  end

  // Credits make an unpopped push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(w_push && !w_pop && (count_q == CNT_W'(FIFO_DEPTH))));
    end
  end

  assign io.rsp_valid = w_rsp_valid;
  assign io.rsp_res   = mem_res_q[rd_ptr_q];
  assign io.rsp_tag   = mem_tag_q[rd_ptr_q];
  assign io.rsp_err   = mem_err_q[rd_ptr_q];
  assign io.proto_err = rst & proto_q;

endmodule
`default_nettype wire

// File: tb/tb_saph_fpu_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_saph_fpu_issue
// Purpose  : Self-checking bench for saph_fpu_issue (LATENCY=2, TAG_W=5,
//            FIFO_DEPTH=4) with a behavioural 2-cycle FPU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_saph_fpu_issue;
  localparam int LAT   = 2;
  localparam int TW    = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  saph_fpu_issue_if #(.TAG_W(TW)) bus ();

  saph_fpu_issue #(.LATENCY(LAT), .TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // ---------------- FPU model (2-cycle pipeline, never stalls) ------------
  function automatic logic [31:0] fp_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    case ({m, a, b})
      {2'd0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {2'd1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
      {2'd2, 32'h40000000, 32'h40400000}: return 32'h40C00000;
      {2'd3, 32'h40C00000, 32'h40000000}: return 32'h40400000;
      {2'd2, 32'h40400000, 32'h40400000}: return 32'h41100000;
      default:                            return 32'hDEADBEEF;
    endcase
  endfunction

  logic        fv0 = 1'b0, fv1 = 1'b0, force_q = 1'b0;
  logic [31:0] fr0 = '0, fr1 = '0;
  always @(posedge clk) begin
    fv0 <= bus.fpu_d_trig & bus.fpu_d_ready;
    fr0 <= fp_op(bus.fpu_d_mode, bus.fpu_d_lhs, bus.fpu_d_rhs);
    fv1 <= fv0;
    fr1 <= fr0;
  end
  assign bus.fpu_q_trig = fv1 | force_q;
  assign bus.fpu_q_res  = fr1;

  // ---------------- response monitor ---------------------------------------
  typedef struct packed {
    logic [31:0]   res;
    logic [TW-1:0] tag;
    logic          err;
  } rsp_t;
  rsp_t rq[$];

  always @(negedge clk) begin
    #2;
    if (rst && bus.rsp_valid && bus.rsp_ready)
      rq.push_back('{res: bus.rsp_res, tag: bus.rsp_tag, err: bus.rsp_err});
  end

  // ---------------- checking helpers ---------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [TW-1:0] t, output logic trig);
    bit got = 1'b0;
    trig = 1'b0;
    bus.req_valid = 1'b1; bus.req_mode = m; bus.req_lhs = a; bus.req_rhs = b; bus.req_tag = t;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (bus.req_ready) begin trig = bus.fpu_d_trig; got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Back-to-back beat: valid stays high, ready and d_trig checked this cycle.
  task automatic beat(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [TW-1:0] t, input logic exp_trig);
    bus.req_valid = 1'b1; bus.req_mode = m; bus.req_lhs = a; bus.req_rhs = b; bus.req_tag = t;
    #1;
    chk("b2b_ready", 32'(bus.req_ready), 32'd1);
    chk("b2b_trig", 32'(bus.fpu_d_trig), 32'(exp_trig));
    @(negedge clk);
  endtask

  // Latency counted in negedges from the negedge following the accept.
  task automatic get_rsp(output rsp_t r, output int lat);
    lat = -1;
    r   = '0;
    for (int k = 0; k < 40; k++) begin
      #3;
      if (rq.size() > 0) begin r = rq.pop_front(); lat = k; break; end
      @(negedge clk);
    end
    if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [31:0]   lhs;
    logic [31:0]   rhs;
    logic [TW-1:0] tag;
    logic [3:0]    modes;
    logic          exp_trig;
    logic [31:0]   exp_res;
    logic          exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rsp_t r;
    int   lat;
    logic trig;
    int   acc;
    bit   seen_v, seen_p;
    logic [TW-1:0] exp_tags[3];
    logic [31:0]   exp_res[3];
    logic          exp_err[3];

    vt[0] = '{2'd0, 32'h3F800000, 32'h40000000, 5'd3,  4'hF,    1'b1, 32'h40400000, 1'b0};
    vt[1] = '{2'd1, 32'h40400000, 32'h3F800000, 5'd1,  4'hF,    1'b1, 32'h40000000, 1'b0};
    vt[2] = '{2'd2, 32'h40000000, 32'h40400000, 5'd2,  4'hF,    1'b1, 32'h40C00000, 1'b0};
    vt[3] = '{2'd3, 32'h40C00000, 32'h40000000, 5'd4,  4'hF,    1'b1, 32'h40400000, 1'b0};
    vt[4] = '{2'd3, 32'h40C00000, 32'h40000000, 5'd9,  4'b0111, 1'b0, 32'h7FC00000, 1'b1};
    vt[5] = '{2'd0, 32'h3F800000, 32'h40000000, 5'd31, 4'b1110, 1'b0, 32'h7FC00000, 1'b1};
    vt[6] = '{2'd2, 32'h40400000, 32'h40400000, 5'd0,  4'b0100, 1'b1, 32'h41100000, 1'b0};

    bus.req_valid = 1'b0; bus.req_mode = '0; bus.req_lhs = '0; bus.req_rhs = '0; bus.req_tag = '0;
    bus.fpu_has_modes = 4'hF; bus.fpu_d_ready = 1'b1; bus.rsp_ready = 1'b1;

    // ---- reset state ----
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.req_valid = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_d_trig", 32'(bus.fpu_d_trig), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // ---- single-op table ----
    for (int i = 0; i < 7; i++) begin
      bus.fpu_has_modes = vt[i].modes;
      send(vt[i].mode, vt[i].lhs, vt[i].rhs, vt[i].tag, trig);
      chk($sformatf("v%0d_trig", i), 32'(trig), 32'(vt[i].exp_trig));
      get_rsp(r, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_res", i), r.res, vt[i].exp_res);
      chk($sformatf("v%0d_tag", i), 32'(r.tag), 32'(vt[i].tag));
      chk($sformatf("v%0d_err", i), 32'(r.err), 32'(vt[i].exp_err));
    end
    chk("table_proto_err", 32'(bus.proto_err), 32'd0);

    // ---- back-to-back sub / mul / div ----
    bus.fpu_has_modes = 4'hF;
    beat(2'd1, 32'h40400000, 32'h3F800000, 5'd1, 1'b1);
    beat(2'd2, 32'h40000000, 32'h40400000, 5'd2, 1'b1);
    beat(2'd3, 32'h40C00000, 32'h40000000, 5'd4, 1'b1);
    bus.req_valid = 1'b0;
    exp_tags = '{5'd1, 5'd2, 5'd4};
    exp_res  = '{32'h40000000, 32'h40C00000, 32'h40400000};
    for (int i = 0; i < 3; i++) begin
      get_rsp(r, lat);
      chk($sformatf("b2b%0d_res", i), r.res, exp_res[i]);
      chk($sformatf("b2b%0d_tag", i), 32'(r.tag), 32'(exp_tags[i]));
    end

    // ---- unsupported div between two adds ----
    bus.fpu_has_modes = 4'b0111;
    beat(2'd0, 32'h3F800000, 32'h40000000, 5'd5, 1'b1);
    beat(2'd3, 32'h40C00000, 32'h40000000, 5'd9, 1'b0);
    beat(2'd0, 32'h3F800000, 32'h40000000, 5'd6, 1'b1);
    bus.req_valid = 1'b0;
    exp_tags = '{5'd5, 5'd9, 5'd6};
    exp_res  = '{32'h40400000, 32'h7FC00000, 32'h40400000};
    exp_err  = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      get_rsp(r, lat);
      chk($sformatf("mix%0d_res", i), r.res, exp_res[i]);
      chk($sformatf("mix%0d_tag", i), 32'(r.tag), 32'(exp_tags[i]));
      chk($sformatf("mix%0d_err", i), 32'(r.err), 32'(exp_err[i]));
    end
    chk("mix_proto_err", 32'(bus.proto_err), 32'd0);

    // ---- credit backpressure: rsp_ready low ----
    bus.fpu_has_modes = 4'hF;
    repeat (3) @(negedge clk);
    bus.rsp_ready = 1'b0;
    acc = 0;
    bus.req_valid = 1'b1; bus.req_mode = 2'd0;
    bus.req_lhs = 32'h3F800000; bus.req_rhs = 32'h40000000;
    for (int k = 0; k < 10; k++) begin
      bus.req_tag = TW'(10 + acc);
      #1;
      if (bus.req_ready) acc++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    #1;
    chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_rsp(r, lat);
      chk($sformatf("bp%0d_tag", i), 32'(r.tag), 32'(10 + i));
      chk($sformatf("bp%0d_res", i), r.res, 32'h40400000);
    end
    #1;
    chk("bp_resume_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

    // ---- stray result strobe ----
    repeat (4) @(negedge clk);
    #1;
    chk("pre_stray_proto", 32'(bus.proto_err), 32'd0);
    @(negedge clk);
    force_q = 1'b1;
    @(negedge clk);
    force_q = 1'b0;
    #1;
    chk("stray_proto", 32'(bus.proto_err), 32'd1);
    chk("stray_no_rsp", 32'(bus.rsp_valid), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    chk("stray_sticky", 32'(bus.proto_err), 32'd1);
    @(negedge clk);

    // ---- reset with two ops in flight ----
    beat(2'd0, 32'h3F800000, 32'h40000000, 5'd20, 1'b1);
    beat(2'd2, 32'h40000000, 32'h40400000, 5'd21, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_trig", 32'(bus.fpu_d_trig), 32'd0);
    chk("mid_rst_proto", 32'(bus.proto_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    seen_v = 1'b0; seen_p = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus.rsp_valid) seen_v = 1'b1;
      if (bus.proto_err) seen_p = 1'b1;
      @(negedge clk);
    end
    chk("drain_rsp_valid", 32'(seen_v), 32'd0);
    chk("drain_proto_err", 32'(seen_p), 32'd0);
    chk("drain_queue", 32'(rq.size()), 32'd0);

    // ---- recovery after reset ----
    send(2'd0, 32'h3F800000, 32'h40000000, 5'd7, trig);
    chk("post_rst_trig", 32'(trig), 32'd1);
    get_rsp(r, lat);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_tag", 32'(r.tag), 32'd7);
    chk("post_rst_res", r.res, 32'h40400000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
